itch_add_order_tx: RTL and testbench



---
 rtl/itch_pkg.sv | 44 ++++
 rtl/itch_hold_reg.sv | 51 +++++
 rtl/itch_add_order_tx.sv | 156 +++++++++++++++
 tb/tb_itch_add_order_tx.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/itch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : itch_pkg
// Description : Shared ITCH definitions: Add Order message constants, field
//               byte offsets, the Add Order field tuple and the transmitter
//               state encoding. Also used by itch_parser.
// Revision    : 1.0 - initial release
// ============================================================================
package itch_pkg;

  localparam logic [7:0] ITCH_MSG_ADD_ORDER = 8'h41;  // 'A'
  localparam int         ITCH_ADD_ORDER_LEN = 15;     // bytes on the wire

  // Byte offsets of each field within the 15-byte message (byte 0 = type)
  localparam int OID_OFF   = 1;
  localparam int QTY_OFF   = 9;
  localparam int PRICE_OFF = 11;

  localparam int ADD_ORDER_W   = 112;                    // packed tuple width
  localparam int ADD_ORDER_FRW = ITCH_ADD_ORDER_LEN * 8; // 120-bit frame

  typedef struct packed {
    logic [63:0] order_id;
    logic [15:0] quantity;
    logic [31:0] price;
  } add_order_t;

  typedef enum logic [1:0] {
    TX_IDLE = 2'd0,
    TX_SEND = 2'd1,
    TX_GAP  = 2'd2
  } tx_state_t;

  // Builds the wire frame MSB-first so byte 0 sits in the top 8 bits and the
  // shift register can always transmit its most significant byte.
  function automatic logic [ADD_ORDER_FRW-1:0] pack_add_order(
    input logic [7:0] msg_type,
    input add_order_t f
  );
    return {msg_type, f.order_id, f.quantity, f.price};
  endfunction

endpackage
`default_nettype wire

// File: rtl/itch_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : itch_hold_reg
// Description : One-entry holding buffer for an Add Order field tuple.
//               Lets the transmitter accept the next tuple while the current
//               message is still shifting out.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               wr_en        - capture wr_data (only issued while empty)
//               wr_data      - packed add_order_t tuple
//               rd_en        - entry consumed this cycle (only while full)
//               full         - entry holds a valid tuple
//               rd_data      - stored tuple
// Revision    : 1.0 - initial release
// ============================================================================
module itch_hold_reg
  import itch_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [ADD_ORDER_W-1:0] wr_data,
  input  logic                   rd_en,
  output logic                   full,
  output logic [ADD_ORDER_W-1:0] rd_data
);

  logic                   full_r;
  logic [ADD_ORDER_W-1:0] data_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      full_r <= 1'b0;
    end else if (wr_en) begin
      full_r <= 1'b1;
    end else if (rd_en) begin
      full_r <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed while full_r is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      data_r <= wr_data;
    end
  end

  assign full    = full_r;
  assign rd_data = data_r;

endmodule
`default_nettype wire

// File: rtl/itch_add_order_tx.sv
`default_nettype none
// ============================================================================
// Module      : itch_add_order_tx
// Description : Serialises one 15-byte ITCH Add Order message per accepted
//               field tuple onto an 8-bit AXI-Stream. A one-entry holding
//               buffer plus the active shift register let back-to-back
//               messages stream without bubbles.
// Ports       : clk, rst              - clock, synchronous active-high reset
//               in_valid / in_ready   - field tuple handshake
//               order_id, price,
//               quantity              - tuple fields, sent big-endian
//               m_axis_tdata/tvalid/
//               tready/tlast          - AXI-Stream byte output
//               msg_count             - completed messages (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module itch_add_order_tx
  import itch_pkg::*;
#(
  parameter logic [7:0] MSG_TYPE   = ITCH_MSG_ADD_ORDER,
  parameter int         GAP_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] order_id,
  input  logic [31:0] price,
  input  logic [15:0] quantity,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic [15:0] msg_count
);

  localparam logic [3:0] LAST_IDX = 4'(ITCH_ADD_ORDER_LEN - 1);
  localparam logic [7:0] GAP_LOAD = (GAP_CYCLES > 0) ? 8'(GAP_CYCLES - 1) : 8'd0;

  tx_state_t              state, state_nxt;
  logic [ADD_ORDER_FRW-1:0] shreg;
  logic [3:0]             idx;
  logic [7:0]             gap_cnt;
  logic [15:0]            msg_count_r;

  add_order_t             in_tuple;
  logic                   hold_full;
  logic [ADD_ORDER_W-1:0] hold_data;

  logic accept, beat, last_beat;
  logic load_hold, load_direct, hold_wr;

  assign in_tuple = {order_id, quantity, price};

  assign in_ready      = !hold_full;
  assign accept        = in_valid && in_ready;
  assign m_axis_tvalid = (state == TX_SEND);
  assign m_axis_tdata  = shreg[ADD_ORDER_FRW-1 -: 8];
  assign m_axis_tlast  = m_axis_tvalid && (idx == LAST_IDX);
  assign beat          = m_axis_tvalid && m_axis_tready;
  assign last_beat     = beat && (idx == LAST_IDX);
  assign msg_count     = msg_count_r;

  // Any accept that does not go straight into the shift register is parked
  // in the holding buffer; in_ready guarantees the buffer is empty then.
  assign hold_wr = accept && !load_direct;

  itch_hold_reg u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (in_tuple),
    .rd_en   (load_hold),
    .full    (hold_full),
    .rd_data (hold_data)
  );

  always_comb begin
    state_nxt   = state;
    load_hold   = 1'b0;
    load_direct = 1'b0;
    case (state)
      TX_IDLE: begin
        if (hold_full) begin
          load_hold = 1'b1;
          state_nxt = TX_SEND;
        end else if (accept) begin
          load_direct = 1'b1;
          state_nxt   = TX_SEND;
        end
      end
      TX_SEND: begin
        if (last_beat) begin
          if (GAP_CYCLES > 0) begin
            state_nxt = TX_GAP;
          end else if (hold_full) begin
            load_hold = 1'b1;
          end else if (accept) begin
            // New tuple arrives on the last beat: chain it with no bubble.
            load_direct = 1'b1;
          end else begin
            state_nxt = TX_IDLE;
          end
        end
      end
      TX_GAP: begin
        // On the final gap cycle a parked tuple is launched immediately so
        // the idle stretch is exactly GAP_CYCLES long.
        if (gap_cnt == 8'd0) begin
          if (hold_full) begin
            load_hold = 1'b1;
            state_nxt = TX_SEND;
          end else begin
            state_nxt = TX_IDLE;
          end
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= TX_IDLE;
      shreg       <= '0;
      idx         <= 4'd0;
      gap_cnt     <= 8'd0;
      msg_count_r <= 16'd0;
    end else begin
      state <= state_nxt;

      if (load_hold) begin
        shreg <= pack_add_order(MSG_TYPE, add_order_t'(hold_data));
        idx   <= 4'd0;
      end else if (load_direct) begin
        shreg <= pack_add_order(MSG_TYPE, in_tuple);
        idx   <= 4'd0;
      end else if (beat) begin
        shreg <= {shreg[ADD_ORDER_FRW-9:0], 8'h00};
        idx   <= idx + 4'd1;
      end

      if (last_beat) begin
        msg_count_r <= msg_count_r + 16'd1;
      end

      if (state == TX_SEND && state_nxt == TX_GAP) begin
        gap_cnt <= GAP_LOAD;
      end else if (state == TX_GAP && gap_cnt != 8'd0) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_itch_add_order_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_itch_add_order_tx
// Description : Self-checking bench for itch_add_order_tx. Expected bytes are
//               queued when a tuple is accepted and compared as beats appear.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_itch_add_order_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  // Main DUT (no gap)
  logic        in_valid = 1'b0, in_ready;
  logic [63:0] order_id = '0;
  logic [31:0] price = '0;
  logic [15:0] quantity = '0;
  logic [7:0]  tdata;
  logic        tvalid, tlast;
  logic        tready = 1'b1;
  logic [15:0] msg_count;

  // Second DUT with a 3-cycle inter-message gap
  logic        g_in_valid = 1'b0, g_in_ready;
  logic [63:0] g_order_id = '0;
  logic [31:0] g_price = '0;
  logic [15:0] g_quantity = '0;
  logic [7:0]  g_tdata;
  logic        g_tvalid, g_tlast;
  logic        g_tready = 1'b1;
  logic [15:0] g_msg_count;

  itch_add_order_tx #(.MSG_TYPE(8'h41), .GAP_CYCLES(0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .order_id(order_id), .price(price), .quantity(quantity),
    .m_axis_tdata(tdata), .m_axis_tvalid(tvalid), .m_axis_tready(tready),
    .m_axis_tlast(tlast), .msg_count(msg_count)
  );

  itch_add_order_tx #(.MSG_TYPE(8'h41), .GAP_CYCLES(3)) dut_gap (
    .clk(clk), .rst(rst), .in_valid(g_in_valid), .in_ready(g_in_ready),
    .order_id(g_order_id), .price(g_price), .quantity(g_quantity),
    .m_axis_tdata(g_tdata), .m_axis_tvalid(g_tvalid), .m_axis_tready(g_tready),
    .m_axis_tlast(g_tlast), .msg_count(g_msg_count)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [119:0] frame(input logic [63:0] oid, input logic [15:0] q,
                                         input logic [31:0] p);
    return {8'h41, oid, q, p};
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] data; logic last; } beat_t;
  beat_t sb[$];
  int    beat_cyc_q[$];
  int    cyc = 0;

  task automatic push_frame(input logic [119:0] f);
    for (int k = 0; k < 15; k++) begin
      beat_t b;
      b.data = f[119 - 8*k -: 8];
      b.last = (k == 14);
      sb.push_back(b);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // tready pattern: 0 = always high, 1 = toggle each cycle, 2 = held low
  int tr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (tr_mode)
      1:       tready = ~tready;
      2:       tready = 1'b0;
      default: tready = 1'b1;
    endcase
  end

  logic       mid_msg = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] stall_data;
  logic       stall_last;
  beat_t      e;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mid_msg = 1'b0;
      stall   = 1'b0;
    end else begin
      if (stall) begin
        check("stall_tvalid", tvalid, 1'b1);
        check("stall_bytes", {tdata, tlast}, {stall_data, stall_last});
      end else if (mid_msg) begin
        check("tvalid_mid_msg", tvalid, 1'b1);
      end
      stall      = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
      if (tvalid && tready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_beat: got data %0h last %0b, none expected", tdata, tlast);
        end else begin
          e = sb.pop_front();
          check("beat_data", tdata, e.data);
          check("beat_last", tlast, e.last);
          beat_cyc_q.push_back(cyc);
          mid_msg = !tlast;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_tuple(input logic [63:0] oid, input logic [15:0] q,
                            input logic [31:0] p, input logic [119:0] f);
    int  t = 0;
    bit  done = 0;
    in_valid = 1'b1; order_id = oid; quantity = q; price = p;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        push_frame(f);
        done = 1;
      end else if (t > 200) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        done = 1;
      end
      t++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      n_cmp++; n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // ---------------- test vectors ----------------
  typedef struct {
    logic [63:0]  oid;
    logic [15:0]  qty;
    logic [31:0]  price;
    logic [119:0] exp;
  } vec_t;
  vec_t vecs[4];

  int exp_count;
  int b0;
  int t;
  int gap;

  initial begin
    vecs[0] = '{64'h0102030405060708, 16'd100, 32'd10000,
                120'h41_0102030405060708_0064_00002710};
    vecs[1] = '{64'hDEADBEEFCAFEF00D, 16'h1234, 32'h89ABCDEF,
                120'h41_DEADBEEFCAFEF00D_1234_89ABCDEF};
    vecs[2] = '{64'h0, 16'h0, 32'h0,
                120'h41_0000000000000000_0000_00000000};
    vecs[3] = '{64'hFFFFFFFFFFFFFFFF, 16'hFFFF, 32'hFFFFFFFF,
                120'h41_FFFFFFFFFFFFFFFF_FFFF_FFFFFFFF};

    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    exp_count = 0;
    @(negedge clk);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, 8'h00);
    check("rst_msg_count", msg_count, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Table: single messages at full rate, 15 beats on 15 consecutive cycles
    for (int i = 0; i < 4; i++) begin
      b0 = beat_cyc_q.size();
      send_tuple(vecs[i].oid, vecs[i].qty, vecs[i].price, vecs[i].exp);
      drain();
      exp_count++;
      check("single_msg_count", msg_count, 16'(exp_count));
      check("single_beats", beat_cyc_q.size() - b0, 15);
      check("single_span", beat_cyc_q[$] - beat_cyc_q[b0], 14);
    end

    // Backpressure: tready toggles, 15 beats spread over 29 cycles
    tr_mode = 1;
    b0 = beat_cyc_q.size();
    send_tuple(vecs[0].oid, vecs[0].qty, vecs[0].price, vecs[0].exp);
    drain();
    tr_mode = 0;
    exp_count++;
    check("bp_msg_count", msg_count, 16'(exp_count));
    check("bp_span", beat_cyc_q[$] - beat_cyc_q[b0], 28);
    repeat (2) @(posedge clk); #1;

    // Back-to-back tuples: second one parks in hold, 30 contiguous beats
    b0 = beat_cyc_q.size();
    send_tuple(vecs[1].oid, vecs[1].qty, vecs[1].price, vecs[1].exp);
    send_tuple(vecs[3].oid, vecs[3].qty, vecs[3].price, vecs[3].exp);
    drain();
    exp_count += 2;
    check("b2b_msg_count", msg_count, 16'(exp_count));
    check("b2b_beats", beat_cyc_q.size() - b0, 30);
    check("b2b_span", beat_cyc_q[$] - beat_cyc_q[b0], 29);

    // Accept on the same edge as the last-byte handshake: still no bubble
    b0 = beat_cyc_q.size();
    send_tuple(vecs[2].oid, vecs[2].qty, vecs[2].price, vecs[2].exp);
    repeat (14) @(posedge clk);
    #1;
    send_tuple(64'h1122334455667788, 16'h0A0B, 32'h0C0D0E0F,
               frame(64'h1122334455667788, 16'h0A0B, 32'h0C0D0E0F));
    drain();
    exp_count += 2;
    check("chain_msg_count", msg_count, 16'(exp_count));
    check("chain_beats", beat_cyc_q.size() - b0, 30);
    check("chain_span", beat_cyc_q[$] - beat_cyc_q[b0], 29);

    // Hold full: with tready low, the third tuple must stall
    tr_mode = 2;
    tready  = 1'b0;
    send_tuple(64'hA1, 16'd1, 32'd11, frame(64'hA1, 16'd1, 32'd11));
    send_tuple(64'hA2, 16'd2, 32'd22, frame(64'hA2, 16'd2, 32'd22));
    in_valid = 1'b1; order_id = 64'hA3; quantity = 16'd3; price = 32'd33;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("hold_full_in_ready", in_ready, 1'b0);
    end
    @(posedge clk); #1;
    tr_mode = 0;
    send_tuple(64'hA3, 16'd3, 32'd33, frame(64'hA3, 16'd3, 32'd33));
    drain();
    exp_count += 3;
    check("hold_msg_count", msg_count, 16'(exp_count));

    // Reset while byte 6 is on the bus
    send_tuple(vecs[1].oid, vecs[1].qty, vecs[1].price, vecs[1].exp);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    check("midrst_tvalid", tvalid, 1'b0);
    check("midrst_tlast", tlast, 1'b0);
    check("midrst_msg_count", msg_count, 16'd0);
    check("midrst_in_ready", in_ready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;
    exp_count = 0;
    b0 = beat_cyc_q.size();
    send_tuple(vecs[0].oid, vecs[0].qty, vecs[0].price, vecs[0].exp);
    drain();
    exp_count++;
    check("postrst_msg_count", msg_count, 16'(exp_count));
    check("postrst_beats", beat_cyc_q.size() - b0, 15);

    // GAP_CYCLES=3 instance: two queued tuples, exactly 3 idle cycles between
    g_in_valid = 1'b1; g_order_id = 64'h55; g_quantity = 16'd5; g_price = 32'd500;
    @(negedge clk);
    check("gap_ready_1", g_in_ready, 1'b1);
    @(posedge clk); #1;
    g_order_id = 64'h0123456789ABCDEF; g_quantity = 16'hBEEF; g_price = 32'h00C0FFEE;
    @(negedge clk);
    check("gap_ready_2", g_in_ready, 1'b1);
    @(posedge clk); #1;
    g_in_valid = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(g_tvalid && g_tlast) && t < 100);
    check("gap_first_tlast_seen", g_tvalid && g_tlast, 1'b1);
    gap = 0;
    t = 0;
    do begin
      @(negedge clk);
      if (!g_tvalid) gap++;
      t++;
    end while (!g_tvalid && t < 50);
    check("gap_idle_cycles", gap, 3);
    for (int k = 0; k < 15; k++) begin
      logic [119:0] f;
      f = frame(64'h0123456789ABCDEF, 16'hBEEF, 32'h00C0FFEE);
      check("gap_msg2_data", {g_tvalid, g_tdata}, {1'b1, f[119 - 8*k -: 8]});
      check("gap_msg2_last", g_tlast, (k == 14));
      @(negedge clk);
    end
    check("gap_msg_count", g_msg_count, 16'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, %0d compared / %0d mismatched",
             n_cmp, n_err);
    $fatal(1);
  end

endmodule
`default_nettype wire
